// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: two AHB-Lite masters (M0 = Cortex-M0, M1 = secondary
// master) sharing one slave-side bus. Losing address phases are buffered
// and the owning master is stalled through its HREADY until serviced.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects alternating priority
// instead of M0 fixed priority with the MAX_WAIT starvation guard.
module ahb_master_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR_M0,
  input  logic [1:0]  HTRANS_M0,
  input  logic [2:0]  HSIZE_M0,
  input  logic        HWRITE_M0,
  input  logic [31:0] HWDATA_M0,
  input  logic        HMASTLOCK_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [1:0]  HTRANS_M1,
  input  logic [2:0]  HSIZE_M1,
  input  logic        HWRITE_M1,
  input  logic [31:0] HWDATA_M1,
  output logic        HREADY_M0,
  output logic        HREADY_M1,
  output logic [31:0] HRDATA_M,
  output logic [31:0] HADDR_S,
  output logic [1:0]  HTRANS_S,
  output logic [2:0]  HSIZE_S,
  output logic        HWRITE_S,
  output logic [31:0] HWDATA_S,
  input  logic [31:0] HRDATA_S,
  input  logic        HREADY_S,
  output logic        HMASTER
);

  typedef enum logic [1:0] {DP_NONE = 2'd0, DP_M0 = 2'd1, DP_M1 = 2'd2} dp_e;

  localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

  dp_e         dp_q, dp_d;
  logic        pend0_q, pend0_d, pend1_q, pend1_d;
  logic [31:0] bufAddr0_q, bufAddr0_d, bufAddr1_q, bufAddr1_d;
  logic [2:0]  bufSize0_q, bufSize0_d, bufSize1_q, bufSize1_d;
  logic        bufWrite0_q, bufWrite0_d, bufWrite1_q, bufWrite1_d;
  logic        hold_q;
  logic [31:0] frzAddr_q;
  logic [1:0]  frzTrans_q;
  logic [2:0]  frzSize_q;
  logic        frzWrite_q, frzMaster_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;
`else
  logic [7:0]  wait_q, wait_d;
`endif

  logic        ready0, ready1, live0, live1, req0, req1, win;
  logic [31:0] selAddr;
  logic [1:0]  selTrans;
  logic [2:0]  selSize;
  logic        selWrite;
  logic        gntValid, gnt, consume;

  // Qualify requests (live or buffered) and pick the address-phase winner
  always_comb begin
    ready0 = 1'b1;
    if (pend0_q) ready0 = 1'b0;
    else if (dp_q == DP_M0) ready0 = HREADY_S;
    ready1 = 1'b1;
    if (pend1_q) ready1 = 1'b0;
    else if (dp_q == DP_M1) ready1 = HREADY_S;
    live0 = HTRANS_M0[1] & ready0;
    live1 = HTRANS_M1[1] & ready1;
    req0  = pend0_q | live0;
    req1  = pend1_q | live1;
    win   = 1'b0;
    if (req1 && !req0) win = 1'b1;
    else if (req0 && req1 && !HMASTLOCK_M0) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~last_q;
`else
      win = (wait_q >= WaitMax);
`endif
    end
    selAddr  = '0;
    selTrans = 2'b00;
    selSize  = '0;
    selWrite = 1'b0;
    if (win && req1) begin
      if (pend1_q) begin
        selAddr = bufAddr1_q; selTrans = 2'b10; selSize = bufSize1_q; selWrite = bufWrite1_q;
      end else begin
        selAddr = HADDR_M1; selTrans = HTRANS_M1; selSize = HSIZE_M1; selWrite = HWRITE_M1;
      end
    end else if (!win && req0) begin
      if (pend0_q) begin
        selAddr = bufAddr0_q; selTrans = 2'b10; selSize = bufSize0_q; selWrite = bufWrite0_q;
      end else begin
        selAddr = HADDR_M0; selTrans = HTRANS_M0; selSize = HSIZE_M0; selWrite = HWRITE_M0;
      end
    end
  end

  // Drive the slave bus: frozen copy while the slave is stalling, else the winner
  always_comb begin
    if (hold_q) begin
      HADDR_S = frzAddr_q; HTRANS_S = frzTrans_q; HSIZE_S = frzSize_q;
      HWRITE_S = frzWrite_q; HMASTER = frzMaster_q;
    end else begin
      HADDR_S = selAddr; HTRANS_S = selTrans; HSIZE_S = selSize;
      HWRITE_S = selWrite; HMASTER = win;
    end
    case (dp_q)
      DP_M0:   HWDATA_S = HWDATA_M0;
      DP_M1:   HWDATA_S = HWDATA_M1;
      default: HWDATA_S = '0;
    endcase
  end

  assign gntValid  = HTRANS_S[1];
  assign gnt       = HMASTER;
  assign consume   = HREADY_S & gntValid;
  assign HREADY_M0 = ready0;
  assign HREADY_M1 = ready1;
  assign HRDATA_M  = HRDATA_S;

  // Next state: pending buffers, data-phase owner and fairness bookkeeping
  always_comb begin
    pend0_d = pend0_q; bufAddr0_d = bufAddr0_q; bufSize0_d = bufSize0_q; bufWrite0_d = bufWrite0_q;
    pend1_d = pend1_q; bufAddr1_d = bufAddr1_q; bufSize1_d = bufSize1_q; bufWrite1_d = bufWrite1_q;
    if (consume && !gnt) pend0_d = 1'b0;
    else if (live0) begin
      pend0_d = 1'b1; bufAddr0_d = HADDR_M0; bufSize0_d = HSIZE_M0; bufWrite0_d = HWRITE_M0;
    end
    if (consume && gnt) pend1_d = 1'b0;
    else if (live1) begin
      pend1_d = 1'b1; bufAddr1_d = HADDR_M1; bufSize1_d = HSIZE_M1; bufWrite1_d = HWRITE_M1;
    end
    dp_d = dp_q;
    if (HREADY_S) dp_d = !gntValid ? DP_NONE : (gnt ? DP_M1 : DP_M0);
`ifdef ARB_ROUND_ROBIN_EN
    last_d = last_q;
    if (consume) last_d = gnt;
`else
    wait_d = wait_q;
    if (HREADY_S) begin
      if (gntValid && gnt) wait_d = '0;
      else if (gntValid && req1) wait_d = (wait_q >= WaitMax) ? WaitMax : wait_q + 8'd1;
      else if (!req1) wait_d = '0;
    end
`endif
  end

  // Control registers with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_q <= DP_NONE;
      pend0_q <= 1'b0; bufAddr0_q <= '0; bufSize0_q <= '0; bufWrite0_q <= 1'b0;
      pend1_q <= 1'b0; bufAddr1_q <= '0; bufSize1_q <= '0; bufWrite1_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q <= 1'b1;
`else
      wait_q <= '0;
`endif
    end else begin
      dp_q <= dp_d;
      pend0_q <= pend0_d; bufAddr0_q <= bufAddr0_d; bufSize0_q <= bufSize0_d; bufWrite0_q <= bufWrite0_d;
      pend1_q <= pend1_d; bufAddr1_q <= bufAddr1_d; bufSize1_q <= bufSize1_d; bufWrite1_q <= bufWrite1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q <= last_d;
`else
      wait_q <= wait_d;
`endif
    end
  end

  // Snapshot of the presented address phase, replayed while HREADY_S is low
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_q <= 1'b0; frzAddr_q <= '0; frzTrans_q <= 2'b00;
      frzSize_q <= '0; frzWrite_q <= 1'b0; frzMaster_q <= 1'b0;
    end else begin
      hold_q <= ~HREADY_S; frzAddr_q <= HADDR_S; frzTrans_q <= HTRANS_S;
      frzSize_q <= HSIZE_S; frzWrite_q <= HWRITE_S; frzMaster_q <= HMASTER;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed vector table, corner-case sequences and a
// randomized run compared against a transfer-level reference model.
module tb_ahb_master_arbiter;

  localparam int MaxWait = 8;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddrM0, haddrM1, hwdataM0, hwdataM1, hrdataS;
  logic [1:0]  htransM0, htransM1;
  logic [2:0]  hsizeM0, hsizeM1;
  logic        hwriteM0, hwriteM1, hmastlockM0, hreadyS;
  logic        hreadyM0, hreadyM1, hwriteS, hmaster;
  logic [31:0] hrdataM, haddrS, hwdataS;
  logic [1:0]  htransS;
  logic [2:0]  hsizeS;

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_master_arbiter #(.MAX_WAIT(MaxWait)) dut (
    .HCLK(hclk), .HRESET(hreset),
    .HADDR_M0(haddrM0), .HTRANS_M0(htransM0), .HSIZE_M0(hsizeM0), .HWRITE_M0(hwriteM0),
    .HWDATA_M0(hwdataM0), .HMASTLOCK_M0(hmastlockM0),
    .HADDR_M1(haddrM1), .HTRANS_M1(htransM1), .HSIZE_M1(hsizeM1), .HWRITE_M1(hwriteM1),
    .HWDATA_M1(hwdataM1),
    .HREADY_M0(hreadyM0), .HREADY_M1(hreadyM1), .HRDATA_M(hrdataM),
    .HADDR_S(haddrS), .HTRANS_S(htransS), .HSIZE_S(hsizeS), .HWRITE_S(hwriteS),
    .HWDATA_S(hwdataS), .HRDATA_S(hrdataS), .HREADY_S(hreadyS), .HMASTER(hmaster)
  );

  typedef struct {
    logic [1:0]  tr0; logic [31:0] a0; logic [31:0] wd0;
    logic [1:0]  tr1; logic [31:0] a1; logic w1; logic [31:0] wd1;
    logic        rdyS;
    logic [1:0]  eTrans; logic [31:0] eAddr; logic eMaster;
    logic        eRdy0; logic eRdy1; logic [31:0] eWdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr; logic [2:0] size; logic wr; logic [1:0] trans;
  } xfer_t;

  // Reference model: one slot per master for a parked transfer, who owns the
  // data phase (-1 = nobody), and what the bus showed last cycle.
  bit    mPend[2];
  xfer_t mBuf[2];
  int    mDp, mWait, mLast, mShownOwner;
  bit    mStalled;
  xfer_t mShown;
  bit    mLive[2], mReq[2];
  xfer_t eBus;
  int    eOwner;
  logic  eReady[2];
  logic [31:0] eWdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    htransM0 = v.tr0; haddrM0 = v.a0; hwdataM0 = v.wd0; hwriteM0 = 1'b0; hsizeM0 = 3'b010;
    htransM1 = v.tr1; haddrM1 = v.a1; hwdataM1 = v.wd1; hwriteM1 = v.w1; hsizeM1 = 3'b010;
    hreadyS = v.rdyS; hmastlockM0 = 1'b0;
  endtask

  task automatic idleInputs();
    htransM0 = 2'b00; haddrM0 = '0; hwdataM0 = '0; hwriteM0 = 1'b0; hsizeM0 = 3'b010;
    htransM1 = 2'b00; haddrM1 = '0; hwdataM1 = '0; hwriteM1 = 1'b0; hsizeM1 = 3'b010;
    hmastlockM0 = 1'b0; hreadyS = 1'b1; hrdataS = '0;
  endtask

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      mPend[m] = 1'b0; mBuf[m] = '{default: '0};
    end
    mDp = -1; mWait = 0; mLast = 1; mStalled = 1'b0;
    mShown = '{default: '0}; mShownOwner = 0;
  endfunction

  task automatic doReset();
    idleInputs();
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    modelReset();
  endtask

  function automatic xfer_t liveXfer(input int m);
    xfer_t t;
    if (m == 0) t = '{addr: haddrM0, size: hsizeM0, wr: hwriteM0, trans: htransM0};
    else        t = '{addr: haddrM1, size: hsizeM1, wr: hwriteM1, trans: htransM1};
    return t;
  endfunction

  // Expected outputs this cycle from the model state and the present inputs
  function automatic void modelEval();
    int win;
    for (int m = 0; m < 2; m++) begin
      eReady[m] = mPend[m] ? 1'b0 : ((mDp == m) ? hreadyS : 1'b1);
      mLive[m]  = liveXfer(m).trans[1] && eReady[m];
      mReq[m]   = mPend[m] || mLive[m];
    end
    if (mStalled) begin
      eBus = mShown; eOwner = mShownOwner;
    end else if (!mReq[0] && !mReq[1]) begin
      eBus = '{default: '0}; eOwner = 0;
    end else begin
      if (mReq[0] && mReq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = hmastlockM0 ? 0 : 1 - mLast;
`else
        win = hmastlockM0 ? 0 : ((mWait == MaxWait) ? 1 : 0);
`endif
      end else win = mReq[1] ? 1 : 0;
      eOwner = win;
      if (mPend[win]) begin
        eBus = mBuf[win]; eBus.trans = 2'b10;
      end else eBus = liveXfer(win);
    end
    eWdata = (mDp == 0) ? hwdataM0 : (mDp == 1) ? hwdataM1 : 32'h0;
  endfunction

  // Clock-edge update of the model
  function automatic void modelAdvance();
    bit granted;
    granted = eBus.trans[1];
    if (hreset) begin
      modelReset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (hreadyS && granted && eOwner == m) mPend[m] = 1'b0;
      else if (mLive[m]) begin
        mPend[m] = 1'b1; mBuf[m] = liveXfer(m);
      end
    end
    if (hreadyS) begin
      if (granted && eOwner == 1) mWait = 0;
      else if (granted && mReq[1]) mWait = (mWait + 1 > MaxWait) ? MaxWait : mWait + 1;
      else if (!mReq[1]) mWait = 0;
      mDp = granted ? eOwner : -1;
      if (granted) mLast = eOwner;
    end
    mStalled = !hreadyS; mShown = eBus; mShownOwner = eOwner;
  endfunction

  vec_t vecs[13];
  int   firstM1, m1Grants, expFirst;

  initial begin
    // Directed table: reset state, lone M0, contention, stall with SEQ buffering
    vecs[0]  = '{2'd0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 32'h0,        1'b1, 2'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    vecs[1]  = '{2'd2, 32'h2000_0000,32'h0,        2'd0, 32'h0,        1'b0, 32'h0,        1'b1, 2'd2, 32'h2000_0000,1'b0, 1'b1, 1'b1, 32'h0};
    vecs[2]  = '{2'd0, 32'h0,        32'h1111_1111,2'd0, 32'h0,        1'b0, 32'h0,        1'b1, 2'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1111_1111};
    vecs[3]  = '{2'd2, 32'h10,       32'h22,       2'd2, 32'h2000_0100,1'b1, 32'h0,        1'b1, 2'd2, 32'h10,       1'b0, 1'b1, 1'b1, 32'h0};
    vecs[4]  = '{2'd0, 32'h0,        32'h33,       2'd2, 32'h2000_0100,1'b1, 32'h0,        1'b1, 2'd2, 32'h2000_0100,1'b1, 1'b1, 1'b0, 32'h33};
    vecs[5]  = '{2'd0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 32'hCAFE_0001,1'b1, 2'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hCAFE_0001};
    vecs[6]  = '{2'd0, 32'h0,        32'h0,        2'd2, 32'h3000_0000,1'b1, 32'h0,        1'b1, 2'd2, 32'h3000_0000,1'b1, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{2'd0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 32'hDEAD_BEEF,1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{2'd3, 32'h40,       32'h0,        2'd0, 32'h0,        1'b0, 32'hDEAD_BEEF,1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{2'd3, 32'h40,       32'h0,        2'd0, 32'h0,        1'b0, 32'hDEAD_BEEF,1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{2'd3, 32'h40,       32'h0,        2'd0, 32'h0,        1'b0, 32'hDEAD_BEEF,1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[11] = '{2'd3, 32'h40,       32'h0,        2'd0, 32'h0,        1'b0, 32'h0,        1'b1, 2'd2, 32'h40,       1'b0, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{2'd0, 32'h0,        32'h44,       2'd0, 32'h0,        1'b0, 32'h0,        1'b1, 2'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h44};

    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      @(negedge hclk);
      checkOutput($sformatf("vec%0d HTRANS_S", i), 32'(htransS), 32'(vecs[i].eTrans));
      checkOutput($sformatf("vec%0d HADDR_S", i), haddrS, vecs[i].eAddr);
      checkOutput($sformatf("vec%0d HMASTER", i), 32'(hmaster), 32'(vecs[i].eMaster));
      checkOutput($sformatf("vec%0d HREADY_M0", i), 32'(hreadyM0), 32'(vecs[i].eRdy0));
      checkOutput($sformatf("vec%0d HREADY_M1", i), 32'(hreadyM1), 32'(vecs[i].eRdy1));
      checkOutput($sformatf("vec%0d HWDATA_S", i), hwdataS, vecs[i].eWdata);
      @(posedge hclk); #1;
    end

    // Reset while M1 has a parked transfer
    doReset();
    htransM0 = 2'b10; haddrM0 = 32'h100; htransM1 = 2'b10; haddrM1 = 32'h200;
    @(posedge hclk); #1;
    htransM0 = 2'b00;
    @(negedge hclk);
    checkOutput("rst pending HREADY_M1", 32'(hreadyM1), 32'h0);
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0; idleInputs();
    @(negedge hclk);
    checkOutput("rst HTRANS_S", 32'(htransS), 32'h0);
    checkOutput("rst HREADY_M0", 32'(hreadyM0), 32'h1);
    checkOutput("rst HREADY_M1", 32'(hreadyM1), 32'h1);
    checkOutput("rst HMASTER", 32'(hmaster), 32'h0);
    checkOutput("rst HWDATA_S", hwdataS, 32'h0);
    @(posedge hclk); #1;
    @(negedge hclk);
    checkOutput("rst pending dropped", 32'(htransS), 32'h0);
    @(posedge hclk); #1;

    // Starvation guard (or alternation) under continuous M0 traffic
    doReset();
    htransM0 = 2'b10; haddrM0 = 32'h1000; htransM1 = 2'b10; haddrM1 = 32'h2000;
    firstM1 = -1;
    for (int arb = 1; arb <= 20 && firstM1 < 0; arb++) begin
      @(negedge hclk);
      if (htransS[1] && hmaster) firstM1 = arb;
      @(posedge hclk); #1;
      haddrM0 = haddrM0 + 32'd4;
    end
`ifdef ARB_ROUND_ROBIN_EN
    expFirst = 2;
`else
    expFirst = MaxWait + 1;
`endif
    checkOutput("first M1 grant index", 32'(firstM1), 32'(expFirst));
    idleInputs();

    // Locked M0 sequence holds the bus for 12 transfers
    doReset();
    htransM0 = 2'b10; haddrM0 = 32'h1000; hmastlockM0 = 1'b1;
    htransM1 = 2'b10; haddrM1 = 32'h2000;
    m1Grants = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge hclk);
      if (htransS[1] && hmaster) m1Grants++;
      @(posedge hclk); #1;
      haddrM0 = haddrM0 + 32'd4;
    end
    checkOutput("M1 grants under lock", 32'(m1Grants), 32'h0);
    hmastlockM0 = 1'b0;
    @(negedge hclk);
    checkOutput("M1 after unlock HMASTER", 32'(hmaster), 32'h1);
    checkOutput("M1 after unlock HADDR_S", haddrS, 32'h2000);
    @(posedge hclk); #1;
    idleInputs();

    // Randomized traffic against the reference model
    doReset();
    for (int c = 0; c < 600; c++) begin
      htransM0 = 2'($urandom_range(0, 3)); haddrM0 = $urandom; hsizeM0 = 3'($urandom_range(0, 7));
      hwriteM0 = 1'($urandom_range(0, 1)); hwdataM0 = $urandom;
      hmastlockM0 = ($urandom_range(0, 9) == 0);
      htransM1 = 2'($urandom_range(0, 3)); haddrM1 = $urandom; hsizeM1 = 3'($urandom_range(0, 7));
      hwriteM1 = 1'($urandom_range(0, 1)); hwdataM1 = $urandom;
      hreadyS = ($urandom_range(0, 4) != 0); hrdataS = $urandom;
      hreset = ($urandom_range(0, 99) == 0);
      @(negedge hclk);
      modelEval();
      checkOutput($sformatf("rnd%0d HTRANS_S", c), 32'(htransS), 32'(eBus.trans));
      checkOutput($sformatf("rnd%0d HADDR_S", c), haddrS, eBus.addr);
      checkOutput($sformatf("rnd%0d HSIZE_S", c), 32'(hsizeS), 32'(eBus.size));
      checkOutput($sformatf("rnd%0d HWRITE_S", c), 32'(hwriteS), 32'(eBus.wr));
      checkOutput($sformatf("rnd%0d HMASTER", c), 32'(hmaster), 32'(eOwner));
      checkOutput($sformatf("rnd%0d HREADY_M0", c), 32'(hreadyM0), 32'(eReady[0]));
      checkOutput($sformatf("rnd%0d HREADY_M1", c), 32'(hreadyM1), 32'(eReady[1]));
      checkOutput($sformatf("rnd%0d HWDATA_S", c), hwdataS, eWdata);
      checkOutput($sformatf("rnd%0d HRDATA_M", c), hrdataM, hrdataS);
      modelAdvance();
      @(posedge hclk); #1;
    end
    hreset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
